// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the 8-bit bus CPU control path.
//   - 4-bit instruction opcodes (IR upper nibble)
//   - ALU operation codes
//   - sequencer state enumeration
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } seq_state_e;

endpackage

// File: rtl/ring_counter.sv
// -----------------------------------------------------------------------------
// ring_counter
// One-hot T-state counter. Empty (all zero) while the sequencer is idle or
// halted; the first enabled step loads bit0, later steps rotate left and wrap
// from the top bit back to bit0.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears to zero)
//   i_en   in   advance one position
//   i_clr  in   synchronous clear to zero (wins over i_en)
//   o_q    out  one-hot position, bit0 = T1
// -----------------------------------------------------------------------------
module ring_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            // Start from empty or wrap from the last T-state back to T1.
            if (r_q == '0 || r_q[WIDTH-1])
                r_q <= {{(WIDTH-1){1'b0}}, 1'b1};
            else
                r_q <= r_q << 1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Steps each instruction through six fetch/execute T-states and decodes the
// IR opcode into bus load/send strobes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   start/continue, sampled in IDLE and at end of T6
//   opcode[3:0]           IR upper nibble, decoded in T4..T6 only
//   pc_send .. out_load   single-bit bus strobes (combinational)
//   alu_op[3:0]           ALU operation, SUB only in SUB T6
//   tstate[5:0]           one-hot T1..T6, zero in IDLE/HALT
//   halted                high only in HALT
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [3:0]          opcode,
    output logic                pc_send,
    output logic                pc_inc,
    output logic                mar_load,
    output logic                ram_send,
    output logic                ir_load,
    output logic                ir_send,
    output logic                a_load,
    output logic                a_send,
    output logic                b_load,
    output logic                alu_send,
    output logic                out_load,
    output logic [3:0]          alu_op,
    output logic [T_STATES-1:0] tstate,
    output logic                halted
);

    seq_state_e r_state;
    seq_state_e w_next;
    logic       w_rc_en;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: w_next = run ? S_T1 : S_IDLE;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3:   w_next = S_T4;
            S_T4:   w_next = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:   w_next = S_T6;
            S_T6:   w_next = run ? S_T1 : S_IDLE;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // The ring counter tracks the same T-state as r_state: it advances
    // whenever the next state is a T-state and empties on IDLE/HALT.
    assign w_rc_en = (w_next != S_IDLE) && (w_next != S_HALT);

    ring_counter #(.WIDTH(T_STATES)) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_rc_en),
        .i_clr (!w_rc_en),
        .o_q   (tstate)
    );

    // ---------------- output decode ----------------
    always_comb begin
        pc_send  = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ram_send = 1'b0;
        ir_load  = 1'b0;
        ir_send  = 1'b0;
        a_load   = 1'b0;
        a_send   = 1'b0;
        b_load   = 1'b0;
        alu_send = 1'b0;
        out_load = 1'b0;
        alu_op   = ALU_ADD;
        halted   = 1'b0;
        unique case (r_state)
            S_T1: begin
                pc_send  = 1'b1;
                mar_load = 1'b1;
            end
            S_T2: pc_inc = 1'b1;
            S_T3: begin
                ram_send = 1'b1;
                ir_load  = 1'b1;
            end
            S_T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    ir_send  = 1'b1;
                    mar_load = 1'b1;
                end else if (opcode == OP_OUT) begin
                    a_send   = 1'b1;
                    out_load = 1'b1;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ram_send = 1'b1;
                    a_load   = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ram_send = 1'b1;
                    b_load   = 1'b1;
                end
            end
            S_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    alu_send = 1'b1;
                    a_load   = 1'b1;
                    alu_op   = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic       pc_send, pc_inc, mar_load, ram_send, ir_load, ir_send;
    logic       a_load, a_send, b_load, alu_send, out_load;
    logic [3:0] alu_op;
    logic [5:0] tstate;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Reference position: 0 = idle, 1..6 = T1..T6, 7 = halted
    int m_t = 0;

    control_sequencer #(.T_STATES(6)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .pc_send(pc_send), .pc_inc(pc_inc), .mar_load(mar_load),
        .ram_send(ram_send), .ir_load(ir_load), .ir_send(ir_send),
        .a_load(a_load), .a_send(a_send), .b_load(b_load),
        .alu_send(alu_send), .out_load(out_load), .alu_op(alu_op),
        .tstate(tstate), .halted(halted)
    );

    always #5 clk = ~clk;

    // {pc_send,pc_inc,mar_load,ram_send,ir_load,ir_send,a_load,a_send,b_load,
    //  alu_send,out_load, alu_op[3:0], tstate[5:0], halted}
    logic [21:0] obs;
    assign obs = {pc_send, pc_inc, mar_load, ram_send, ir_load, ir_send, a_load,
                  a_send, b_load, alu_send, out_load, alu_op, tstate, halted};

    logic [4:0] bus_vec;
    assign bus_vec = {pc_send, ram_send, ir_send, a_send, alu_send};

    // Expected outputs straight from the instruction table.
    function automatic logic [21:0] exp_vec(int t, logic [3:0] op);
        logic [10:0] s;   // strobes in obs order
        logic [3:0]  aop;
        logic [5:0]  ts;
        logic        h;
        s = '0; aop = 4'b0000; ts = '0; h = 1'b0;
        if (t >= 1 && t <= 6) ts = 6'b1 << (t - 1);
        if (t == 7) h = 1'b1;
        case (t)
            1: s = 11'b101_0000_0000;              // pc_send, mar_load
            2: s = 11'b010_0000_0000;              // pc_inc
            3: s = 11'b000_1100_0000;              // ram_send, ir_load
            4: if (op <= 4'd2)       s = 11'b001_0010_0000;  // ir_send, mar_load
               else if (op == 4'hE)  s = 11'b000_0000_1001;  // a_send, out_load
            5: if (op == 4'd0)       s = 11'b000_1001_0000;  // ram_send, a_load
               else if (op <= 4'd2)  s = 11'b000_1000_0100;  // ram_send, b_load
            6: if (op == 4'd1 || op == 4'd2) begin
                   s = 11'b000_0001_0010;                     // alu_send, a_load
                   if (op == 4'd2) aop = 4'b0001;
               end
            default: ;
        endcase
        return {s, aop, ts, h};
    endfunction

    // Drive inputs, take one rising edge, move the model, land on the next
    // falling edge where outputs are sampled.
    task automatic adv(input logic r, input logic [3:0] op);
        run = r;
        opcode = op;
        @(posedge clk);
        case (m_t)
            0:       m_t = r ? 1 : 0;
            4:       m_t = (op == 4'hF) ? 7 : 5;
            6:       m_t = r ? 1 : 0;
            7:       m_t = 7;
            default: m_t = m_t + 1;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_t = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; opcode = 4'h1;
        #2;
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs, 22'd0);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL reset_hold got=%h exp=%h", obs, 22'd0);
        end
        run = 1'b0;
        rst_n = 1'b1;
        m_t = 0;
        adv(1'b0, 4'h1);
        checks++;
        if (obs !== exp_vec(m_t, opcode)) begin
            errors++; $display("FAIL idle_hold got=%h exp=%h", obs, exp_vec(m_t, opcode));
        end
    endtask

    // One full instruction of the given opcode with random opcode in fetch.
    task automatic test_instr(input logic [3:0] op, input string nm);
        logic [3:0] o;
        for (int k = 1; k <= 6; k++) begin
            o = (k >= 4) ? op : 4'($urandom);
            adv(1'b1, o);
            checks++;
            if (m_t != k || obs !== exp_vec(k, o)) begin
                errors++;
                $display("FAIL %s_T%0d got=%h exp=%h", nm, k, obs, exp_vec(k, o));
            end
        end
    endtask

    task automatic test_add();
        test_instr(4'h1, "add");
        test_instr(4'h1, "add_b2b");
    endtask

    task automatic test_sub();
        test_instr(4'h2, "sub");
        // alu_op must be SUB only in T6
        checks++;
        if (alu_op !== 4'b0001) begin
            errors++; $display("FAIL sub_aluop got=%h exp=%h", alu_op, 4'b0001);
        end
        adv(1'b1, 4'h2);
        checks++;
        if (alu_op !== 4'b0000 || tstate !== 6'b000001) begin
            errors++; $display("FAIL sub_next_T1 got=%h/%b exp=0/000001", alu_op, tstate);
        end
        adv(1'b1, 4'h2); adv(1'b1, 4'h2); adv(1'b1, 4'h2);
        adv(1'b1, 4'h2); adv(1'b1, 4'h2);   // finish in T6
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 5; k++) adv(1'b1, (k >= 4) ? 4'h1 : 4'($urandom));
        #2 rst_n = 1'b0;
        #1;
        m_t = 0;
        checks++;
        if (obs !== 22'd0) begin
            errors++; $display("FAIL async_reset_midT5 got=%h exp=0", obs);
        end
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        adv(1'b0, 4'h1);
        checks++;
        if (obs !== exp_vec(m_t, opcode)) begin
            errors++; $display("FAIL post_reset_idle got=%h exp=%h", obs, exp_vec(m_t, opcode));
        end
    endtask

    task automatic test_lda_run_drop();
        logic r;
        for (int k = 1; k <= 6; k++) begin
            r = (k <= 3);              // run falls while in T3
            adv(r, (k >= 4) ? 4'h0 : 4'($urandom));
            checks++;
            if (obs !== exp_vec(k, opcode)) begin
                errors++; $display("FAIL lda_drop_T%0d got=%h exp=%h", k, obs, exp_vec(k, opcode));
            end
        end
        for (int k = 0; k < 3; k++) begin
            adv(1'b0, 4'($urandom));
            checks++;
            if (obs !== 22'd0) begin
                errors++; $display("FAIL lda_drop_idle got=%h exp=0", obs);
            end
        end
    endtask

    task automatic test_out_hlt();
        test_instr(4'hE, "out");
        for (int k = 1; k <= 4; k++) begin
            adv(1'b1, (k >= 4) ? 4'hF : 4'($urandom));
            checks++;
            if (obs !== exp_vec(k, opcode)) begin
                errors++; $display("FAIL hlt_T%0d got=%h exp=%h", k, obs, exp_vec(k, opcode));
            end
        end
        for (int k = 0; k < 20; k++) begin
            adv(1'b1, (k == 0) ? 4'hF : 4'($urandom));
            checks++;
            if (m_t != 7 || halted !== 1'b1 || tstate !== 6'd0 || obs !== exp_vec(7, opcode)) begin
                errors++; $display("FAIL halt_hold_%0d got=%h exp=%h", k, obs, exp_vec(7, opcode));
            end
        end
        do_reset();
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 16; op++) begin
            for (int k = 1; k <= 6; k++) begin
                adv(1'b1, (k >= 4) ? 4'(op) : 4'($urandom));
                checks++;
                if (obs !== exp_vec(m_t, opcode) || $countones(bus_vec) > 1) begin
                    errors++;
                    $display("FAIL sweep_op%0h_T%0d got=%h exp=%h", op, k, obs, exp_vec(m_t, opcode));
                end
                if (m_t == 7) break;
            end
            if (m_t == 7) do_reset();
        end
        adv(1'b0, 4'h0);
        if (m_t != 0) do_reset();
    endtask

    task automatic test_random();
        logic r;
        logic [3:0] o;
        for (int i = 0; i < 500; i++) begin
            if (m_t == 7 && $urandom_range(0, 7) == 0) do_reset();
            r = ($urandom_range(0, 5) != 0);
            o = 4'($urandom);
            adv(r, o);
            checks++;
            if (obs !== exp_vec(m_t, opcode) || $countones(bus_vec) > 1) begin
                errors++;
                $display("FAIL random_%0d t=%0d got=%h exp=%h", i, m_t, obs, exp_vec(m_t, opcode));
            end
        end
    endtask

    initial begin
        run = 1'b0; opcode = 4'h0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_reset_mid();
        test_lda_run_drop();
        test_out_hlt();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
